// File: rtl/ahb_slave_if_param.sv
// rtl/ahb_slave_if_param.sv - AHB-side slave interface of the AHB2APB bridge, N-slave decode, 2-stage pipeline
// Optional ERROR response for out-of-window transfers: define AHB_ERR_RESP_EN.
module ahb_slave_if_param #(
  parameter int                 ADDR_W        = 32,
  parameter int                 DATA_W        = 32,
  parameter int                 NUM_SLV       = 3,
  parameter logic [ADDR_W-1:0]  BASE_ADDR     = 32'h8000_0000,
  parameter int                 SLV_SIZE_LOG2 = 26
) (
  input  logic                Hclk,
  input  logic                Hresetn,
  input  logic                Hwrite,
  input  logic                Hreadyin,
  input  logic [1:0]          Htrans,
  input  logic [ADDR_W-1:0]   Haddr,
  input  logic [DATA_W-1:0]   Hwdata,
  input  logic [DATA_W-1:0]   Prdata,
  output logic                valid,
  output logic [ADDR_W-1:0]   Haddr1,
  output logic [ADDR_W-1:0]   Haddr2,
  output logic [DATA_W-1:0]   Hwdata1,
  output logic [DATA_W-1:0]   Hwdata2,
  output logic                Hwritereg,
  output logic                Hwritereg1,
  output logic [NUM_SLV-1:0]  tempselx,
  output logic [DATA_W-1:0]   Hrdata,
  output logic [1:0]          Hresp,
  output logic                Hreadyout,
  output logic [7:0]          err_cnt
);

  // Window bounds carry one extra bit so the exclusive top never wraps to zero.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + ((ADDR_W+1)'(NUM_SLV) << SLV_SIZE_LOG2);

  logic [ADDR_W-1:0] r_haddr1, r_haddr2;
  logic [DATA_W-1:0] r_hwdata1, r_hwdata2;
  logic              r_hwrite1, r_hwrite2;
  logic              w_in_win;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_slot;
  logic              w_xfer;

  assign w_in_win = ({1'b0, Haddr} >= WIN_LO) && ({1'b0, Haddr} < WIN_HI);
  assign w_offset = Haddr - BASE_ADDR;
  assign w_slot   = w_offset >> SLV_SIZE_LOG2;
  assign w_xfer   = Hreadyin && Htrans[1];

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
    assign tempselx[i] = w_in_win && (w_slot == ADDR_W'(i));
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_haddr1  <= '0;
      r_haddr2  <= '0;
      r_hwdata1 <= '0;
      r_hwdata2 <= '0;
      r_hwrite1 <= 1'b0;
      r_hwrite2 <= 1'b0;
    end else begin
      r_haddr1  <= Haddr;
      r_haddr2  <= r_haddr1;
      r_hwdata1 <= Hwdata;
      r_hwdata2 <= r_hwdata1;
      r_hwrite1 <= Hwrite;
      r_hwrite2 <= r_hwrite1;
    end
  end

  assign Haddr1     = r_haddr1;
  assign Haddr2     = r_haddr2;
  assign Hwdata1    = r_hwdata1;
  assign Hwdata2    = r_hwdata2;
  assign Hwritereg  = r_hwrite1;
  assign Hwritereg1 = r_hwrite2;
  assign Hrdata     = Prdata;

`ifdef AHB_ERR_RESP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t     r_state;
  logic [1:0] r_hresp;
  logic       r_hreadyout;
  logic [7:0] r_err_cnt;
  logic       w_err_trig;

  assign w_err_trig = w_xfer && !w_in_win;

  // Two-cycle ERROR: first with HREADY low, then with HREADY high.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state     <= ST_IDLE;
      r_hresp     <= 2'b00;
      r_hreadyout <= 1'b1;
      r_err_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hresp     <= 2'b01;
          r_hreadyout <= 1'b1;
        end
        default: begin
          if (w_err_trig) begin
            r_state     <= ST_ERR1;
            r_hresp     <= 2'b01;
            r_hreadyout <= 1'b0;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else begin
            r_state     <= ST_IDLE;
            r_hresp     <= 2'b00;
            r_hreadyout <= 1'b1;
          end
        end
      endcase
    end
  end

  assign valid     = w_xfer && w_in_win && (r_state != ST_ERR1);
  assign Hresp     = r_hresp;
  assign Hreadyout = r_hreadyout;
  assign err_cnt   = r_err_cnt;
  logic w_unused;
  assign w_unused  = Htrans[0];
`else
  assign valid     = w_xfer && w_in_win;
  assign Hresp     = 2'b00;
  assign Hreadyout = 1'b1;
  assign err_cnt   = 8'd0;
  logic w_unused;
  assign w_unused  = Htrans[0];
`endif

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// tb/tb_ahb_slave_if_param.sv - directed self-checking bench for ahb_slave_if_param (default parameters)
module tb_ahb_slave_if_param;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        valid;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic        Hwritereg, Hwritereg1;
  logic [2:0]  tempselx;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_slave_if_param dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
    .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .Hwritereg1(Hwritereg1),
    .tempselx(tempselx), .Hrdata(Hrdata), .Hresp(Hresp),
    .Hreadyout(Hreadyout), .err_cnt(err_cnt)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rdy, input logic [1:0] tr,
                       input logic [31:0] a, input logic [31:0] d);
    Hwrite = wr; Hreadyin = rdy; Htrans = tr; Haddr = a; Hwdata = d;
  endtask

  initial begin
    Hresetn = 1'b0;
    Prdata  = 32'h0;
    drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    #100;
    chk("rst_haddr1", Haddr1, 0);
    chk("rst_haddr2", Haddr2, 0);
    chk("rst_hwdata1", Hwdata1, 0);
    chk("rst_hwdata2", Hwdata2, 0);
    chk("rst_hwritereg", Hwritereg, 0);
    chk("rst_hwritereg1", Hwritereg1, 0);
    chk("rst_hresp", Hresp, 2'b00);
    chk("rst_hreadyout", Hreadyout, 1);
    chk("rst_err_cnt", err_cnt, 0);

    @(negedge Hclk);
    Hresetn = 1'b1;
    @(negedge Hclk);

    drive(1'b1, 1'b1, 2'b10, 32'h8000_0001, 32'hDEAD_BEEF);
    #1;
    chk("wr_valid", valid, 1);
    chk("wr_sel", tempselx, 3'b001);
    @(posedge Hclk); #1;
    chk("p1_haddr1", Haddr1, 32'h8000_0001);
    chk("p1_hwdata1", Hwdata1, 32'hDEAD_BEEF);
    chk("p1_hwritereg", Hwritereg, 1);
    chk("p1_haddr2", Haddr2, 0);
    @(negedge Hclk);
    drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    @(posedge Hclk); #1;
    chk("p2_haddr2", Haddr2, 32'h8000_0001);
    chk("p2_hwdata2", Hwdata2, 32'hDEAD_BEEF);
    chk("p2_hwritereg1", Hwritereg1, 1);
    chk("p2_haddr1", Haddr1, 0);
    chk("p2_hwritereg", Hwritereg, 0);

    @(negedge Hclk);
    drive(1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h0); #1;
    chk("dec_base_sel", tempselx, 3'b001);
    chk("dec_base_valid", valid, 1);
    Haddr = 32'h8400_0000; #1;
    chk("dec_s1_sel", tempselx, 3'b010);
    chk("dec_s1_valid", valid, 1);
    Haddr = 32'h8BFF_FFFF; Htrans = 2'b11; #1;
    chk("dec_s2top_sel", tempselx, 3'b100);
    chk("dec_s2top_valid", valid, 1);
    Haddr = 32'h8C00_0000; Htrans = 2'b10; #1;
    chk("dec_end_sel", tempselx, 3'b000);
    chk("dec_end_valid", valid, 0);
    Haddr = 32'h7FFF_FFFF; #1;
    chk("dec_below_sel", tempselx, 3'b000);
    chk("dec_below_valid", valid, 0);

    Haddr = 32'h8000_0004; Htrans = 2'b01; #1;
    chk("busy_valid", valid, 0);
    chk("busy_sel", tempselx, 3'b001);
    Htrans = 2'b00; #1;
    chk("idle_valid", valid, 0);
    Htrans = 2'b10; Hreadyin = 1'b0; #1;
    chk("nrdy_valid", valid, 0);
    chk("nrdy_sel", tempselx, 3'b001);
    chk("nrdy_hresp", Hresp, 2'b00);
    Prdata = 32'hCAFE_BABE; #1;
    chk("hrdata", Hrdata, 32'hCAFE_BABE);
    Hreadyin = 1'b0; Haddr = 32'h9000_0000;
    @(posedge Hclk); #1;
    chk("nrdy_oow_hresp", Hresp, 2'b00);
    chk("nrdy_oow_cnt", err_cnt, 0);

`ifdef AHB_ERR_RESP_EN
    @(negedge Hclk);
    drive(1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0);
    @(posedge Hclk); #1;
    chk("err1_hresp", Hresp, 2'b01);
    chk("err1_rdy", Hreadyout, 0);
    chk("err1_cnt", err_cnt, 1);
    @(negedge Hclk);
    Htrans = 2'b00;
    @(posedge Hclk); #1;
    chk("err2_hresp", Hresp, 2'b01);
    chk("err2_rdy", Hreadyout, 1);
    @(posedge Hclk); #1;
    chk("err_done_hresp", Hresp, 2'b00);
    chk("err_done_rdy", Hreadyout, 1);
    chk("err_done_cnt", err_cnt, 1);

    @(negedge Hclk);
    Htrans = 2'b10;
    repeat (700) @(posedge Hclk);
    #1;
    chk("err_sat_cnt", err_cnt, 8'd255);

    @(negedge Hclk);
    Htrans = 2'b00;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    Htrans = 2'b10;
    @(posedge Hclk); #1;
    chk("rst_err1_hresp_pre", Hresp, 2'b01);
    Hresetn = 1'b0; #1;
    chk("rst_err1_hresp", Hresp, 2'b00);
    chk("rst_err1_rdy", Hreadyout, 1);
    chk("rst_err1_cnt", err_cnt, 0);
    @(negedge Hclk);
    Htrans = 2'b00;
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    chk("post_rst_hresp", Hresp, 2'b00);
    chk("post_rst_rdy", Hreadyout, 1);
`else
    @(negedge Hclk);
    drive(1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge Hclk); #1;
      chk("noerr_hresp", Hresp, 2'b00);
      chk("noerr_rdy", Hreadyout, 1);
      chk("noerr_valid", valid, 0);
      chk("noerr_cnt", err_cnt, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
